// File: rtl/reorder_buffer_pkg.sv
// reorder_buffer_pkg: shared default widths and flag constants for the reorder buffer
package reorder_buffer_pkg;
   localparam int DEF_ROB_LEN = 4;
   localparam int DEF_REG_LEN = 5;
   localparam int DEF_DATA_LEN = 32;
   localparam logic TRUE = 1'b1;
   localparam logic FALSE = 1'b0;
endpackage

// File: rtl/reorder_buffer_query_port.sv
// rob_query_port: combinational operand lookup by rename tag with CDB bypass
module rob_query_port
   import reorder_buffer_pkg::*;
#(
   parameter int ROB_LEN = DEF_ROB_LEN,
   parameter int DATA_LEN = DEF_DATA_LEN
) (
   input  logic [ROB_LEN:0]                     query,
   input  logic                                 cdb_en,
   input  logic [ROB_LEN:0]                     cdb_tag,
   input  logic [DATA_LEN-1:0]                  cdb_val,
   input  logic [2**ROB_LEN-1:0]                ready,
   input  logic [2**ROB_LEN-1:0][DATA_LEN-1:0]  val,
   output logic                                 q_ready,
   output logic [DATA_LEN-1:0]                  v
);
   logic [ROB_LEN-1:0] idx;
   logic none;
   logic hit;
   // tag 0 means no dependency; a live CDB broadcast wins over stored entry state
   always_comb begin
      idx = query[ROB_LEN-1:0] - 1'b1;
      none = query == '0;
      hit = cdb_en && cdb_tag == query;
      q_ready = none || hit || ready[idx] == TRUE;
      v = none ? '0 : hit ? cdb_val : val[idx];
   end
endmodule

// File: rtl/reorder_buffer.sv
// reorder_buffer: circular ROB with in-order commit, CDB capture and mispredict rollback
module reorder_buffer
   import reorder_buffer_pkg::*;
#(
   parameter int ROB_LEN = DEF_ROB_LEN,
   parameter int REG_LEN = DEF_REG_LEN,
   parameter int DATA_LEN = DEF_DATA_LEN
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                alloc_en,
   input  logic [REG_LEN-1:0]  alloc_rd,
   input  logic                alloc_is_br,
   output logic [ROB_LEN:0]    alloc_tag,
   output logic                full,
   input  logic [ROB_LEN:0]    q1_query,
   input  logic [ROB_LEN:0]    q2_query,
   output logic                q1_ready,
   output logic                q2_ready,
   output logic [DATA_LEN-1:0] v1_fwd,
   output logic [DATA_LEN-1:0] v2_fwd,
   input  logic                cdb_en,
   input  logic [ROB_LEN:0]    cdb_tag,
   input  logic [DATA_LEN-1:0] cdb_val,
   input  logic                cdb_mispred,
   input  logic [DATA_LEN-1:0] cdb_target,
   output logic                commit_flag,
   output logic [REG_LEN-1:0]  commit_rd,
   output logic [ROB_LEN:0]    commit_q,
   output logic [DATA_LEN-1:0] commit_v,
   output logic                rollback_flag,
   output logic [DATA_LEN-1:0] rollback_pc
);
   localparam int ROB_SIZE = 2**ROB_LEN;
   logic [ROB_SIZE-1:0] busy, ready, is_br, mispred;
   logic [ROB_SIZE-1:0][REG_LEN-1:0] rd;
   logic [ROB_SIZE-1:0][DATA_LEN-1:0] val, target;
   logic [ROB_LEN-1:0] head, tail, wb_idx;
   logic [ROB_LEN:0] count, count_next;
   logic wb_ok, do_commit, do_flush, do_alloc;
   // per-cycle decisions, all taken from registered state so commit never sees a same-cycle CDB write
   always_comb begin
      wb_idx = cdb_tag[ROB_LEN-1:0] - 1'b1;
      wb_ok = cdb_en && cdb_tag != '0 && (!cdb_tag[ROB_LEN] || cdb_tag[ROB_LEN-1:0] == '0) && busy[wb_idx];
      do_commit = busy[head] && ready[head];
      do_flush = do_commit && is_br[head] && mispred[head];
      do_alloc = alloc_en && !full && !rollback_flag;
      count_next = (do_alloc && !do_commit) ? count + 1'b1 : (!do_alloc && do_commit) ? count - 1'b1 : count;
      alloc_tag = {1'b0, tail} + 1'b1;
   end
   // entry storage, pointers and registered commit/rollback outputs; a flush discards same-cycle writes
   always_ff @(posedge clk) begin
      if (rst) begin
         busy <= '0;
         ready <= '0;
         head <= '0;
         tail <= '0;
         count <= '0;
         full <= FALSE;
         commit_flag <= FALSE;
         commit_rd <= '0;
         commit_q <= '0;
         commit_v <= '0;
         rollback_flag <= FALSE;
         rollback_pc <= '0;
      end else begin
         commit_flag <= do_commit;
         rollback_flag <= do_flush;
         if (do_commit) begin
            commit_rd <= rd[head];
            commit_q <= {1'b0, head} + 1'b1;
            commit_v <= val[head];
         end
         if (do_flush) rollback_pc <= target[head];
         if (do_flush) begin
            busy <= '0;
            head <= '0;
            tail <= '0;
            count <= '0;
            full <= FALSE;
         end else begin
            if (wb_ok) begin
               ready[wb_idx] <= TRUE;
               val[wb_idx] <= cdb_val;
               mispred[wb_idx] <= cdb_mispred;
               target[wb_idx] <= cdb_target;
            end
            if (do_commit) begin
               busy[head] <= FALSE;
               head <= head + 1'b1;
            end
            if (do_alloc) begin
               busy[tail] <= TRUE;
               ready[tail] <= FALSE;
               rd[tail] <= alloc_rd;
               is_br[tail] <= alloc_is_br;
               tail <= tail + 1'b1;
            end
            count <= count_next;
            full <= count_next[ROB_LEN];
         end
      end
   end
   rob_query_port #(.ROB_LEN(ROB_LEN), .DATA_LEN(DATA_LEN)) u_q1 (
      .query(q1_query), .cdb_en(cdb_en), .cdb_tag(cdb_tag), .cdb_val(cdb_val),
      .ready(ready), .val(val), .q_ready(q1_ready), .v(v1_fwd)
   );
   rob_query_port #(.ROB_LEN(ROB_LEN), .DATA_LEN(DATA_LEN)) u_q2 (
      .query(q2_query), .cdb_en(cdb_en), .cdb_tag(cdb_tag), .cdb_val(cdb_val),
      .ready(ready), .val(val), .q_ready(q2_ready), .v(v2_fwd)
   );
endmodule

// File: tb/tb_reorder_buffer.sv
// tb_reorder_buffer: randomized and directed checking of reorder_buffer against a queue-based model
module tb_reorder_buffer;
   logic clk = 0, rst = 0;
   logic alloc_en = 0, alloc_is_br = 0;
   logic [4:0] alloc_rd = 0, alloc_tag;
   logic full;
   logic [4:0] q1_query = 0, q2_query = 0;
   logic q1_ready, q2_ready;
   logic [31:0] v1_fwd, v2_fwd;
   logic cdb_en = 0, cdb_mispred = 0;
   logic [4:0] cdb_tag = 0;
   logic [31:0] cdb_val = 0, cdb_target = 0;
   logic commit_flag, rollback_flag;
   logic [4:0] commit_rd, commit_q;
   logic [31:0] commit_v, rollback_pc;
   int vectors = 0, errors = 0;

   reorder_buffer dut (
      .clk(clk), .rst(rst), .alloc_en(alloc_en), .alloc_rd(alloc_rd), .alloc_is_br(alloc_is_br),
      .alloc_tag(alloc_tag), .full(full), .q1_query(q1_query), .q2_query(q2_query),
      .q1_ready(q1_ready), .q2_ready(q2_ready), .v1_fwd(v1_fwd), .v2_fwd(v2_fwd),
      .cdb_en(cdb_en), .cdb_tag(cdb_tag), .cdb_val(cdb_val), .cdb_mispred(cdb_mispred),
      .cdb_target(cdb_target), .commit_flag(commit_flag), .commit_rd(commit_rd),
      .commit_q(commit_q), .commit_v(commit_v), .rollback_flag(rollback_flag),
      .rollback_pc(rollback_pc)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [4:0] tag;
      logic [4:0] rd;
      logic is_br;
      logic ready;
      logic mispred;
      logic [31:0] val;
      logic [31:0] target;
   } ent_t;

   // model: program-order queue of in-flight instructions, head first
   ent_t mq[$];
   logic [4:0] m_tag = 1;
   logic m_valid = 0, m_after_rst = 0;
   logic m_full = 0, m_cf = 0, m_rb = 0;
   logic [4:0] m_crd = 0, m_cq = 0;
   logic [31:0] m_cv = 0, m_rpc = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   always @(posedge clk) begin : model
      bit c, f, a;
      if (rst) begin
         mq.delete();
         m_tag = 1;
         m_full = 0; m_cf = 0; m_rb = 0;
         m_crd = 0; m_cq = 0; m_cv = 0; m_rpc = 0;
         m_valid = 1; m_after_rst = 1;
      end else if (m_valid) begin
         m_after_rst = 0;
         c = mq.size() > 0 && mq[0].ready;
         f = c && mq[0].is_br && mq[0].mispred;
         a = alloc_en && !m_full && !m_rb;
         m_cf = c;
         m_rb = f;
         if (c) begin
            m_crd = mq[0].rd; m_cq = mq[0].tag; m_cv = mq[0].val;
         end
         if (f) begin
            m_rpc = mq[0].target;
            mq.delete();
            m_tag = 1;
            m_full = 0;
         end else begin
            if (cdb_en)
               foreach (mq[i])
                  if (mq[i].tag == cdb_tag) begin
                     mq[i].ready = 1; mq[i].val = cdb_val;
                     mq[i].mispred = cdb_mispred; mq[i].target = cdb_target;
                  end
            if (c) void'(mq.pop_front());
            if (a) begin
               mq.push_back('{tag: m_tag, rd: alloc_rd, is_br: alloc_is_br, ready: 1'b0,
                              mispred: 1'b0, val: 32'h0, target: 32'h0});
               m_tag = (m_tag == 16) ? 5'd1 : m_tag + 5'd1;
            end
            m_full = mq.size() == 16;
         end
      end
   end

   task automatic chk_query(input string nm, input logic [4:0] qt, input logic rdy, input logic [31:0] v);
      if (qt == 0) begin
         chk({nm, "_ready"}, 32'(rdy), 1);
         chk({nm, "_val"}, v, 0);
      end else if (cdb_en && cdb_tag == qt) begin
         chk({nm, "_ready"}, 32'(rdy), 1);
         chk({nm, "_val"}, v, cdb_val);
      end else
         foreach (mq[i])
            if (mq[i].tag == qt) begin
               chk({nm, "_ready"}, 32'(rdy), 32'(mq[i].ready));
               if (mq[i].ready) chk({nm, "_val"}, v, mq[i].val);
            end
   endtask

   // compare process: every cycle, away from the clock edge
   always @(negedge clk) begin
      if (m_valid) begin
         chk("full", 32'(full), 32'(m_full));
         chk("alloc_tag", 32'(alloc_tag), 32'(m_tag));
         chk("commit_flag", 32'(commit_flag), 32'(m_cf));
         chk("rollback_flag", 32'(rollback_flag), 32'(m_rb));
         if (m_cf || m_after_rst) begin
            chk("commit_rd", 32'(commit_rd), 32'(m_crd));
            chk("commit_q", 32'(commit_q), 32'(m_cq));
            chk("commit_v", commit_v, m_cv);
         end
         if (m_rb || m_after_rst) chk("rollback_pc", rollback_pc, m_rpc);
         chk_query("q1", q1_query, q1_ready, v1_fwd);
         chk_query("q2", q2_query, q2_ready, v2_fwd);
      end
   end

   task automatic idle();
      rst = 0; alloc_en = 0; alloc_rd = 0; alloc_is_br = 0;
      cdb_en = 0; cdb_tag = 0; cdb_val = 0; cdb_mispred = 0; cdb_target = 0;
      q1_query = 0; q2_query = 0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      idle();
   endtask

   task automatic do_reset();
      rst = 1;
      tick();
   endtask

   task automatic alloc(input logic [4:0] rd, input logic br);
      alloc_en = 1; alloc_rd = rd; alloc_is_br = br;
      tick();
   endtask

   task automatic wb(input logic [4:0] tag, input logic [31:0] v, input logic mp, input logic [31:0] tgt);
      cdb_en = 1; cdb_tag = tag; cdb_val = v; cdb_mispred = mp; cdb_target = tgt;
      tick();
   endtask

   function automatic logic [4:0] pick();
      if (mq.size() > 0 && $urandom_range(0, 3) != 0) return mq[$urandom_range(0, mq.size() - 1)].tag;
      return 5'($urandom);
   endfunction

   initial begin
      @(posedge clk);
      #1;
      // reset values, then a single allocate/writeback/commit
      do_reset();
      chk("rst_full", 32'(full), 0);
      chk("rst_commit_flag", 32'(commit_flag), 0);
      chk("rst_commit_rd", 32'(commit_rd), 0);
      chk("rst_commit_q", 32'(commit_q), 0);
      chk("rst_commit_v", commit_v, 0);
      chk("rst_rollback_flag", 32'(rollback_flag), 0);
      chk("rst_rollback_pc", rollback_pc, 0);
      alloc_en = 1; alloc_rd = 5;
      #1 chk("first_tag", 32'(alloc_tag), 1);
      tick();
      wb(1, 32'h1234, 0, 0);
      chk("no_commit_yet", 32'(commit_flag), 0);
      tick();
      chk("c1_flag", 32'(commit_flag), 1);
      chk("c1_rd", 32'(commit_rd), 5);
      chk("c1_q", 32'(commit_q), 1);
      chk("c1_v", commit_v, 32'h1234);
      tick();
      chk("c1_pulse", 32'(commit_flag), 0);
      // out-of-order writeback, in-order commit
      do_reset();
      alloc(1, 0); alloc(2, 0); alloc(3, 0);
      wb(3, 32'h33, 0, 0); wb(2, 32'h22, 0, 0); wb(1, 32'h11, 0, 0);
      tick();
      chk("ooo_q1", 32'(commit_q), 1);
      chk("ooo_v1", commit_v, 32'h11);
      tick();
      chk("ooo_q2", 32'(commit_q), 2);
      chk("ooo_f2", 32'(commit_flag), 1);
      tick();
      chk("ooo_q3", 32'(commit_q), 3);
      chk("ooo_v3", commit_v, 32'h33);
      tick();
      chk("ooo_done", 32'(commit_flag), 0);
      // fill, overflow attempt, commit with blocked allocate, wrap
      do_reset();
      for (int i = 0; i < 16; i++) alloc(5'(i), 0);
      chk("fill_full", 32'(full), 1);
      chk("fill_wrap_tag", 32'(alloc_tag), 1);
      alloc(9, 0);
      chk("overflow_full", 32'(full), 1);
      wb(1, 32'hAA, 0, 0);
      alloc(9, 0);
      chk("fill_commit_q", 32'(commit_q), 1);
      chk("fill_after_commit", 32'(full), 0);
      alloc_en = 1; alloc_rd = 9;
      #1 chk("wrap_tag", 32'(alloc_tag), 1);
      tick();
      chk("refull", 32'(full), 1);
      // bypass and tag-0 query
      do_reset();
      for (int i = 0; i < 4; i++) alloc(5'(i + 1), 0);
      q1_query = 4; q2_query = 3; cdb_en = 1; cdb_tag = 4; cdb_val = 32'hBEEF;
      #1;
      chk("byp_ready", 32'(q1_ready), 1);
      chk("byp_val", v1_fwd, 32'hBEEF);
      chk("pending_ready", 32'(q2_ready), 0);
      q2_query = 0;
      #1;
      chk("tag0_ready", 32'(q2_ready), 1);
      chk("tag0_val", v2_fwd, 0);
      tick();
      q1_query = 4;
      #1 chk("stored_val", v1_fwd, 32'hBEEF);
      tick();
      // mispredicted branch flushes younger entries
      do_reset();
      alloc(0, 1); alloc(7, 0); alloc(8, 0);
      wb(1, 32'h44, 1, 32'h100);
      cdb_en = 1; cdb_tag = 2; cdb_val = 32'h77;
      tick();
      chk("rb_flag", 32'(rollback_flag), 1);
      chk("rb_pc", rollback_pc, 32'h100);
      chk("rb_tag", 32'(alloc_tag), 1);
      alloc(9, 0);
      chk("rb_pulse", 32'(rollback_flag), 0);
      chk("rb_no_alloc_tag", 32'(alloc_tag), 1);
      wb(3, 32'h88, 0, 0);
      chk("rb_no_commit", 32'(commit_flag), 0);
      tick();
      chk("rb_still_none", 32'(commit_flag), 0);
      // reset with live entries and a ready head
      do_reset();
      for (int i = 0; i < 5; i++) alloc(5'(i + 1), 0);
      wb(1, 32'h5, 0, 0);
      do_reset();
      chk("mid_rst_commit", 32'(commit_flag), 0);
      chk("mid_rst_full", 32'(full), 0);
      chk("mid_rst_tag", 32'(alloc_tag), 1);
      // randomized traffic against the model
      for (int n = 0; n < 4000; n++) begin
         rst = $urandom_range(0, 499) == 0;
         alloc_en = $urandom_range(0, 1) == 1;
         alloc_rd = 5'($urandom);
         alloc_is_br = $urandom_range(0, 3) == 0;
         cdb_en = $urandom_range(0, 1) == 1;
         cdb_tag = ($urandom_range(0, 7) != 0) ? pick() : 5'($urandom);
         cdb_val = $urandom;
         cdb_mispred = $urandom_range(0, 3) == 0;
         cdb_target = $urandom;
         q1_query = pick();
         q2_query = pick();
         tick();
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
